// File: rtl/psum_drain.sv
// psum_drain
//   Read side of the partial-sum buffer. After a convolution pass it fetches
//   psum rows (ARRAY_DIM lanes of ACC_WIDTH bits) from the psum BRAM read port
//   and serialises them, lane 0 first, onto a valid/ready output stream for
//   host/DMA readback. Only one row is in flight at a time (no prefetch).
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   start               begin a drain; only honoured in IDLE
//   base_addr, num_rows first row address / row count, latched on accepted start
//   busy, done          drain in progress / one-cycle completion pulse
//   mem_ren, mem_raddr  BRAM read enable and address
//   mem_rdata           BRAM read data, valid RD_LATENCY cycles after mem_ren
//   m_tdata, m_tvalid,
//   m_tready, m_tlast   output stream; m_tlast marks the final word of the drain
module psum_drain #(
    parameter int ARRAY_DIM  = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    input  logic [ADDR_WIDTH:0]             num_rows,
    output logic                            busy,
    output logic                            done,
    output logic                            mem_ren,
    output logic [ADDR_WIDTH-1:0]           mem_raddr,
    input  logic [ARRAY_DIM*ACC_WIDTH-1:0]  mem_rdata,
    output logic [ACC_WIDTH-1:0]            m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast
);

    localparam int                  LANE_W    = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
    localparam logic [LANE_W-1:0]   LANE_LAST = LANE_W'(ARRAY_DIM - 1);
    localparam logic [1:0]          WAIT_LAST = 2'(RD_LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] ONE_ROW   = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_STREAM = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                               state_q, state_d;
    logic [ADDR_WIDTH-1:0]                base_q, base_d;
    logic [ADDR_WIDTH:0]                  num_q, num_d;
    // One bit wider than the address so a full 2^ADDR_WIDTH drain can terminate.
    logic [ADDR_WIDTH:0]                  row_idx_q, row_idx_d;
    logic [LANE_W-1:0]                    lane_q, lane_d;
    logic [1:0]                           wait_cnt_q, wait_cnt_d;
    logic [ARRAY_DIM-1:0][ACC_WIDTH-1:0]  row_buf_q, row_buf_d;
    logic [ADDR_WIDTH-1:0]                mem_raddr_q, mem_raddr_d;
    logic                                 busy_q, busy_d;
    logic                                 done_q, done_d;
    logic                                 mem_ren_q, mem_ren_d;
    logic                                 m_tvalid_q, m_tvalid_d;
    logic                                 m_tlast_q, m_tlast_d;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        num_d       = num_q;
        row_idx_d   = row_idx_q;
        lane_d      = lane_q;
        wait_cnt_d  = wait_cnt_q;
        row_buf_d   = row_buf_q;
        mem_raddr_d = mem_raddr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d    = base_addr;
                    num_d     = num_rows;
                    row_idx_d = '0;
                    lane_d    = '0;
                    if (num_rows == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_FETCH;
                        mem_raddr_d = base_addr;
                    end
                end
            end
            S_FETCH: begin
                state_d    = S_WAIT;
                wait_cnt_d = '0;
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    row_buf_d = mem_rdata;
                    lane_d    = '0;
                    state_d   = S_STREAM;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            S_STREAM: begin
                if (m_tready) begin
                    if (lane_q == LANE_LAST) begin
                        row_idx_d = row_idx_q + ONE_ROW;
                        if (row_idx_d == num_q) begin
                            state_d = S_DONE;
                        end else begin
                            state_d     = S_FETCH;
                            // Address arithmetic wraps modulo the BRAM depth.
                            mem_raddr_d = base_q + row_idx_d[ADDR_WIDTH-1:0];
                        end
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        busy_d     = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_STREAM);
        done_d     = (state_d == S_DONE);
        mem_ren_d  = (state_d == S_FETCH);
        m_tvalid_d = (state_d == S_STREAM);
        m_tlast_d  = m_tvalid_d && (lane_d == LANE_LAST) && (row_idx_d == num_d - ONE_ROW);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            num_q       <= '0;
            row_idx_q   <= '0;
            lane_q      <= '0;
            wait_cnt_q  <= '0;
            row_buf_q   <= '0;
            mem_raddr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_ren_q   <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            num_q       <= num_d;
            row_idx_q   <= row_idx_d;
            lane_q      <= lane_d;
            wait_cnt_q  <= wait_cnt_d;
            row_buf_q   <= row_buf_d;
            mem_raddr_q <= mem_raddr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_ren_q   <= mem_ren_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_ren   = mem_ren_q;
    assign mem_raddr = mem_raddr_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tlast   = m_tlast_q;
    // The lane counter only moves on a handshake, so the word is stable under stall.
    assign m_tdata   = row_buf_q[lane_q];

endmodule

// File: tb/tb_psum_drain.sv
module tb_psum_drain;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [9:0]    base_addr = '0;
    logic [10:0]   num_rows = '0;
    logic          busy, done, mem_ren, m_tvalid, m_tlast;
    logic [9:0]    mem_raddr;
    logic [511:0]  mem_rdata = '0;
    logic [31:0]   m_tdata;
    logic          m_tready = 1'b1;

    psum_drain #(.ARRAY_DIM(16), .ACC_WIDTH(32), .ADDR_WIDTH(10), .RD_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_rows(num_rows),
        .busy(busy), .done(done), .mem_ren(mem_ren), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Row r, lane i holds {r, i+1}; row 10 lane 0 is a negative accumulator.
    function automatic logic [31:0] lane_val(input int r, input int i);
        if (r == 10 && i == 0) return 32'hFFFF_FFF6;
        return 32'((r << 16) | (i + 1));
    endfunction

    // BRAM model, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_ren) begin
            for (int i = 0; i < 16; i++) mem_rdata[i*32 +: 32] <= lane_val(int'(mem_raddr), i);
        end
    end

    // Sink ready: constant 1, or random 50% when rand_mode is set.
    bit rand_mode = 1'b0;
    always begin
        @(posedge clk);
        #1;
        m_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard: {tlast, tdata} entries pushed by the stimulus.
    logic [32:0] exp_q[$];
    logic [9:0]  raddr_log[$];
    logic [31:0] hs_log[$];
    int ren_cnt = 0, done_cnt = 0, busy_cnt = 0, tv_cnt = 0, hs_cnt = 0, tlast_cnt = 0;
    int done_cyc = -1, tv_rise_cyc = -1, last_hs_cyc = -1;
    bit tv_prev = 1'b0, stalled = 1'b0, stall_last = 1'b0;
    logic [31:0] stall_data = '0;

    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (mem_ren) begin
                ren_cnt++;
                raddr_log.push_back(mem_raddr);
                check("ren_while_tvalid", m_tvalid, 0);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_cnt++;
            if (m_tvalid) begin
                tv_cnt++;
                if (!tv_prev) tv_rise_cyc = cyc;
                if (stalled) begin
                    check("stall_data", m_tdata, stall_data);
                    check("stall_last", m_tlast, stall_last);
                end
            end else if (stalled) begin
                check("tvalid_dropped", m_tvalid, 1);
            end
            if (m_tvalid && m_tready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                hs_log.push_back(m_tdata);
                if (m_tlast) tlast_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_empty: got word %0h with nothing expected", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_tlast, m_tdata} !== e) begin
                        failures++;
                        $display("FAIL sb_word: got last=%0b data=%0h expected last=%0b data=%0h",
                                 m_tlast, m_tdata, e[32], e[31:0]);
                    end
                end
            end
            stalled    = m_tvalid && !m_tready;
            stall_data = m_tdata;
            stall_last = m_tlast;
        end
        tv_prev = rst_n && m_tvalid;
    end

    int t_start;

    task automatic drain(input int base, input int num);
        for (int r = 0; r < num; r++)
            for (int i = 0; i < 16; i++)
                exp_q.push_back({(r == num - 1) && (i == 15), lane_val((base + r) % 1024, i)});
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 10'(base);
        num_rows  = 11'(num);
        t_start   = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        for (int k = 0; k < 3000 && done_cnt == d0; k++) @(negedge clk);
        check({name, "_done_seen"}, done_cnt > d0, 1);
    endtask

    int r0, d0, h0, b0, t0, v0, l0;

    task automatic snap();
        r0 = ren_cnt; d0 = done_cnt; h0 = hs_cnt; b0 = busy_cnt; v0 = tv_cnt; l0 = tlast_cnt;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ren", mem_ren, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_raddr", mem_raddr, 0);
        check("rst_tdata", m_tdata, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: single row, ready held high, latency checks
        snap();
        drain(0, 1);
        wait_done(d0, "t1");
        check("t1_ren", ren_cnt - r0, 1);
        check("t1_words", hs_cnt - h0, 16);
        check("t1_tlast", tlast_cnt - l0, 1);
        check("t1_first_tvalid", tv_rise_cyc, t_start + 3);
        check("t1_done_cyc", done_cyc, last_hs_cyc + 1);
        check("t1_sb_empty", exp_q.size(), 0);

        // 2: three rows with random backpressure
        repeat (3) @(posedge clk);
        snap();
        rand_mode = 1'b1;
        drain(20, 3);
        wait_done(d0, "t2");
        rand_mode = 1'b0;
        check("t2_ren", ren_cnt - r0, 3);
        check("t2_words", hs_cnt - h0, 48);
        check("t2_tlast", tlast_cnt - l0, 1);
        check("t2_sb_empty", exp_q.size(), 0);

        // 3: address wrap 1023 -> 0
        repeat (3) @(posedge clk);
        snap();
        drain(1023, 2);
        wait_done(d0, "t3");
        check("t3_ren", ren_cnt - r0, 2);
        check("t3_raddr0", raddr_log[r0], 10'd1023);
        check("t3_raddr1", raddr_log[r0 + 1], 10'd0);
        check("t3_word0", hs_log[h0], 32'h03FF_0001);
        check("t3_word16", hs_log[h0 + 16], 32'h0000_0001);
        check("t3_sb_empty", exp_q.size(), 0);

        // 4: zero rows
        repeat (3) @(posedge clk);
        snap();
        drain(5, 0);
        wait_done(d0, "t4");
        repeat (2) @(posedge clk);
        check("t4_done_cyc", done_cyc, t_start + 1);
        check("t4_busy", busy_cnt - b0, 0);
        check("t4_ren", ren_cnt - r0, 0);
        check("t4_tvalid", tv_cnt - v0, 0);
        check("t4_done_pulses", done_cnt - d0, 1);

        // 5: reset mid-drain after 5th word, then clean drain of row 4
        repeat (3) @(posedge clk);
        snap();
        drain(30, 2);
        for (int k = 0; k < 200 && hs_cnt - h0 < 5; k++) @(negedge clk);
        check("t5_five_words", hs_cnt - h0, 5);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t5_tvalid_after_rst", m_tvalid, 0);
        check("t5_busy_after_rst", busy, 0);
        check("t5_tlast_after_rst", m_tlast, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        check("t5_idle_tvalid", m_tvalid, 0);
        snap();
        drain(4, 1);
        wait_done(d0, "t5");
        check("t5_words", hs_cnt - h0, 16);
        check("t5_tlast", tlast_cnt - l0, 1);
        check("t5_word0", hs_log[h0], 32'h0004_0001);
        check("t5_word15", hs_log[h0 + 15], 32'h0004_0010);
        check("t5_sb_empty", exp_q.size(), 0);

        // 6: start during STREAM is ignored
        repeat (3) @(posedge clk);
        snap();
        drain(10, 1);
        for (int k = 0; k < 50 && !m_tvalid; k++) @(negedge clk);
        check("t6_streaming", m_tvalid, 1);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 10'd7;
        num_rows  = 11'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(d0, "t6");
        repeat (4) @(posedge clk);
        #1;
        check("t6_ren", ren_cnt - r0, 1);
        check("t6_words", hs_cnt - h0, 16);
        check("t6_lane0", hs_log[h0], 32'hFFFF_FFF6);
        check("t6_raddr", raddr_log[r0], 10'd10);
        check("t6_idle_after", busy, 0);
        check("t6_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
